// File: rtl/mult_arbiter.sv
// Shares one Q8.8 multiplier among NREQ requesters; tags track product order.
// Ports: clk, rst, req/req_a/req_b in, gnt out, mul_inp1/mul_inp2/mul_in_stb
// to the multiplier, mul_out/mul_out_stb from it, rsp_valid/rsp_data back to
// requesters, busy, sticky err. Define MULT_ARB_FIXED_PRIO_EN for fixed
// priority (lowest index wins) instead of round-robin.
module mult_arbiter #(
  parameter int NREQ       = 4,
  parameter int TAGQ_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      gnt,
  output logic [15:0]          mul_inp1,
  output logic [15:0]          mul_inp2,
  output logic                 mul_in_stb,
  input  logic [15:0]          mul_out,
  input  logic                 mul_out_stb,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [15:0]          rsp_data,
  output logic                 busy,
  output logic                 err
);

  localparam int IW = $clog2(NREQ);
  localparam int PW = $clog2(TAGQ_DEPTH);
  localparam int CW = $clog2(TAGQ_DEPTH + 1);

  logic [IW-1:0] tagq [TAGQ_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] occ;
  logic [CW-1:0] occ_nxt;
  logic [NREQ-1:0] elig;
  logic [IW-1:0] win;
  logic found;
  logic issue;
  logic pop;

  // A requester seen granted this cycle may not win again right away.
  assign elig = req & ~gnt;

`ifdef MULT_ARB_FIXED_PRIO_EN
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        found = 1'b1;
        win   = IW'(i);
      end
    end
  end
`else
  logic [IW-1:0] last_grant;

  // Search order starts just after the previous winner.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && elig[IW'(last_grant + IW'(k) + IW'(1))]) begin
        found = 1'b1;
        win   = IW'(last_grant + IW'(k) + IW'(1));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_grant <= IW'(NREQ - 1);
    else if (issue)
      last_grant <= win;
  end
`endif

  // Fullness is judged on current occupancy; a same-cycle pop does not help.
  assign issue   = found && (occ < CW'(TAGQ_DEPTH));
  assign pop     = mul_out_stb && (occ != '0);
  assign occ_nxt = occ + CW'(issue) - CW'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt        <= '0;
      mul_in_stb <= 1'b0;
      mul_inp1   <= 16'h0000;
      mul_inp2   <= 16'h0000;
      rsp_valid  <= '0;
      rsp_data   <= 16'h0000;
      busy       <= 1'b0;
      err        <= 1'b0;
      occ        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      for (int i = 0; i < TAGQ_DEPTH; i++)
        tagq[i] <= '0;
    end else begin
      gnt        <= '0;
      mul_in_stb <= issue;
      rsp_valid  <= '0;
      if (issue) begin
        gnt[win]     <= 1'b1;
        mul_inp1     <= req_a[16*win +: 16];
        mul_inp2     <= req_b[16*win +: 16];
        tagq[wr_ptr] <= win;
        wr_ptr       <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rsp_valid[tagq[rd_ptr]] <= 1'b1;
        rsp_data                <= mul_out;
        rd_ptr                  <= rd_ptr + PW'(1);
      end
      if (mul_out_stb && (occ == '0))
        err <= 1'b1;
      occ  <= occ_nxt;
      busy <= (occ_nxt != '0);
    end
  end

endmodule
